// File: rtl/aq_pkg.sv
// Shared types and sizes for the Aquarius single-port RAM scheduler.
package aq_pkg;

  localparam int AQ_RAM_AW = 16;
  localparam int AQ_RAM_DW = 8;

  // Which requester owns the read data returning from the RAM this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_TAPE = 2'd2
  } rd_owner_t;

  // Per-cycle owner of the RAM port.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LD   = 2'd2,
    GNT_TAPE = 2'd3
  } gnt_t;

endpackage

// File: rtl/aq_wbuf1.sv
// One-entry write buffer: holds a single addr/data pair until popped.
// A push while full is dropped and latches a sticky overflow flag, unless
// the entry is leaving in the same cycle, in which case the push refills it.
module aq_wbuf1 #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          ovf
);

  logic accept;

  assign accept = push && (!valid || pop);

  // Entry register and sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        valid <= 1'b1;
        addr  <= push_addr;
        data  <= push_data;
      end else if (pop) begin
        valid <= 1'b0;
      end
      if (push && !accept) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aq_mem_arbiter.sv
// Shares one synchronous RAM port between the Z80 (slot-locked to cpu_ce),
// the ioctl loader (one-entry write buffer) and the tape reader (req/ack).
// Read data comes back one cycle after the grant; rd_owner records who it
// belongs to. In that return cycle cpu_q/tp_q show mem_q directly (the RAM
// output register) and afterwards hold the captured copy.
import aq_pkg::*;

module aq_mem_arbiter #(
  parameter int AW = AQ_RAM_AW,
  parameter int DW = AQ_RAM_DW
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_ce,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_q,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_busy,
  output logic          ld_ovf,
  input  logic          tp_req,
  input  logic [AW-1:0] tp_addr,
  output logic          tp_ack,
  output logic [DW-1:0] tp_q,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_q
);

  gnt_t          gnt;
  rd_owner_t     rd_owner;
  logic          rr_last;      // 0: loader served last, 1: tape served last
  logic          ld_valid;
  logic [AW-1:0] ld_buf_addr;
  logic [DW-1:0] ld_buf_data;
  logic          tp_pend;
  logic [AW-1:0] tp_addr_r;
  logic          tp_accept;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] din_hold;
  logic [DW-1:0] cpu_q_r;
  logic [DW-1:0] tp_q_r;
  logic          cpu_rd_done;

  aq_wbuf1 #(.AW(AW), .DW(DW)) u_ld_buf (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (ld_wr),
    .push_addr (ld_addr),
    .push_data (ld_data),
    .pop       (gnt == GNT_LD),
    .valid     (ld_valid),
    .addr      (ld_buf_addr),
    .data      (ld_buf_data),
    .ovf       (ld_ovf)
  );

  assign ld_busy = ld_valid;

  // A tape request is taken only when no read is pending or returning.
  assign tp_accept = tp_req && !tp_pend && (rd_owner != RD_TAPE);

  // Reset suppresses the return-cycle view so an in-flight read never acks.
  assign tp_ack      = (rd_owner == RD_TAPE) && !reset;
  assign cpu_rd_done = (rd_owner == RD_CPU) && !reset;
  assign tp_q        = tp_ack ? mem_q : tp_q_r;
  assign cpu_q       = cpu_rd_done ? mem_q : cpu_q_r;

  // Grant: CPU slot first, then round-robin between loader and tape.
  always_comb begin
    gnt = GNT_IDLE;
    if (!reset) begin
      if (cpu_ce) begin
        gnt = GNT_CPU;
      end else if (ld_valid && tp_pend) begin
        gnt = rr_last ? GNT_LD : GNT_TAPE;
      end else if (ld_valid) begin
        gnt = GNT_LD;
      end else if (tp_pend) begin
        gnt = GNT_TAPE;
      end
    end
  end

  // Port mux; an idle port keeps presenting the last address and data.
  always_comb begin
    mem_addr = addr_hold;
    mem_din  = din_hold;
    mem_we   = 1'b0;
    case (gnt)
      GNT_CPU: begin
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        mem_we   = cpu_we;
      end
      GNT_LD: begin
        mem_addr = ld_buf_addr;
        mem_din  = ld_buf_data;
        mem_we   = 1'b1;
      end
      GNT_TAPE: begin
        mem_addr = tp_addr_r;
      end
      default: ;
    endcase
  end

  // Scheduler state: port hold, fairness pointer, tape request, read owner.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_hold <= '0;
      din_hold  <= '0;
      rr_last   <= 1'b0;
      tp_pend   <= 1'b0;
      tp_addr_r <= '0;
      rd_owner  <= RD_NONE;
    end else begin
      if (gnt != GNT_IDLE) begin
        addr_hold <= mem_addr;
        din_hold  <= mem_din;
      end
      if (gnt == GNT_LD) begin
        rr_last <= 1'b0;
      end else if (gnt == GNT_TAPE) begin
        rr_last <= 1'b1;
      end
      if (gnt == GNT_TAPE) begin
        tp_pend <= 1'b0;
      end else if (tp_accept) begin
        tp_pend   <= 1'b1;
        tp_addr_r <= tp_addr;
      end
      if (gnt == GNT_CPU && !cpu_we) begin
        rd_owner <= RD_CPU;
      end else if (gnt == GNT_TAPE) begin
        rd_owner <= RD_TAPE;
      end else begin
        rd_owner <= RD_NONE;
      end
    end
  end

  // Capture returning read data so it holds until that owner's next read.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_q_r <= '0;
      tp_q_r  <= '0;
    end else begin
      if (rd_owner == RD_CPU) begin
        cpu_q_r <= mem_q;
      end
      if (rd_owner == RD_TAPE) begin
        tp_q_r <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_aq_mem_arbiter.sv
// Bench for aq_mem_arbiter: a directed vector table walking the main
// scenarios, then randomized traffic against a behavioural model.
module tb_aq_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        ce;
    logic        cwe;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic        lw;
    logic [15:0] la;
    logic [7:0]  ldd;
    logic        tr;
    logic [15:0] ta;
    logic        ewe;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ebusy;
    logic        eovf;
    logic        eack;
    logic [7:0]  etpq;
    logic [7:0]  ecpuq;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } ld_ent_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cpu_ce, cpu_we, ld_wr, tp_req;
  logic [15:0] cpu_addr, ld_addr, tp_addr;
  logic [7:0]  cpu_din, ld_data;
  logic [7:0]  cpu_q, tp_q, mem_din, mem_q;
  logic        ld_busy, ld_ovf, tp_ack, mem_we;
  logic [15:0] mem_addr;

  always #5 clk_sys = ~clk_sys;

  aq_mem_arbiter #(.AW(16), .DW(8)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cpu_ce   (cpu_ce),
    .cpu_addr (cpu_addr),
    .cpu_we   (cpu_we),
    .cpu_din  (cpu_din),
    .cpu_q    (cpu_q),
    .ld_wr    (ld_wr),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_busy  (ld_busy),
    .ld_ovf   (ld_ovf),
    .tp_req   (tp_req),
    .tp_addr  (tp_addr),
    .tp_ack   (tp_ack),
    .tp_q     (tp_q),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_q    (mem_q)
  );

  // ---------------- RAM (bench side) ----------------
  logic [7:0]  ram [0:65535];
  bit          ram_ok [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = 16'h0;
  logic [7:0]  pre_d = 8'h0;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk_sys) begin
    if (pre_we) begin
      ram[pre_a]    <= pre_d;
      ram_ok[pre_a] <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr]    <= mem_din;
      ram_ok[mem_addr] <= 1'b1;
    end
    mem_q <= ram_ok[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    return ram_ok[a] ? ram[a] : init_val(a);
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  shadow [0:65535];
  bit          sh_ok [0:65535];
  ld_ent_t     m_ldq[$];
  logic [7:0]  exp_q[$];
  bit          m_ovf, m_tp_pend, m_last_ld, m_cpu_due, m_tp_due;
  logic [15:0] m_tp_addr, m_hold_a;
  logic [7:0]  m_hold_d, m_cpu_val, m_cpu_q, m_tp_q;
  int          m_ld_age, m_tp_age;
  bit          fair_on = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [7:0] sh_rd(input logic [15:0] a);
    return sh_ok[a] ? shadow[a] : init_val(a);
  endfunction

  task automatic sh_wr(input logic [15:0] a, input logic [7:0] d);
    shadow[a] = d;
    sh_ok[a]  = 1'b1;
  endtask

  task automatic model_reset();
    m_ldq.delete();
    exp_q.delete();
    m_ovf = 0; m_tp_pend = 0; m_last_ld = 1; m_cpu_due = 0; m_tp_due = 0;
    m_tp_addr = 16'h0; m_hold_a = 16'h0; m_hold_d = 8'h0;
    m_cpu_val = 8'h0; m_cpu_q = 8'h0; m_tp_q = 8'h0;
    m_ld_age = 0; m_tp_age = 0;
  endtask

  // 0 idle, 1 cpu, 2 loader, 3 tape: whoever was not served last wins a tie.
  function automatic int m_who();
    if (reset) return 0;
    if (cpu_ce) return 1;
    if (m_ldq.size() != 0 && m_tp_pend) return m_last_ld ? 3 : 2;
    if (m_ldq.size() != 0) return 2;
    if (m_tp_pend) return 3;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int          who;
    logic        e_we, e_ack;
    logic [15:0] e_a;
    logic [7:0]  e_d, e_tpq, e_cpuq;
    who  = m_who();
    e_we = 1'b0; e_a = m_hold_a; e_d = m_hold_d;
    if (who == 1) begin
      e_we = cpu_we; e_a = cpu_addr; e_d = cpu_din;
    end else if (who == 2) begin
      e_we = 1'b1; e_a = m_ldq[0].a; e_d = m_ldq[0].d;
    end else if (who == 3) begin
      e_a = m_tp_addr;
    end
    e_ack  = m_tp_due && !reset;
    e_tpq  = (e_ack && exp_q.size() != 0) ? exp_q[0] : m_tp_q;
    e_cpuq = (m_cpu_due && !reset) ? m_cpu_val : m_cpu_q;
    chk("m_mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("m_mem_addr", {16'd0, mem_addr}, {16'd0, e_a});
    chk("m_mem_din", {24'd0, mem_din}, {24'd0, e_d});
    chk("m_ld_busy", {31'd0, ld_busy}, {31'd0, m_ldq.size() != 0});
    chk("m_ld_ovf", {31'd0, ld_ovf}, {31'd0, m_ovf});
    chk("m_tp_ack", {31'd0, tp_ack}, {31'd0, e_ack});
    chk("m_tp_q", {24'd0, tp_q}, {24'd0, e_tpq});
    chk("m_cpu_q", {24'd0, cpu_q}, {24'd0, e_cpuq});
    if (fair_on && m_ldq.size() != 0) chk("m_ld_wait", {31'd0, m_ld_age <= 4}, 32'd1);
    if (fair_on && m_tp_pend) chk("m_tp_wait", {31'd0, m_tp_age <= 4}, 32'd1);
  endtask

  task automatic model_edge();
    int  who;
    bit  tp_busy, ld_new, tp_new;
    who     = m_who();
    tp_busy = m_tp_pend || m_tp_due;
    ld_new  = 1'b0;
    tp_new  = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_cpu_due) m_cpu_q = m_cpu_val;
    if (m_tp_due && exp_q.size() != 0) m_tp_q = exp_q.pop_front();
    m_cpu_due = 0;
    m_tp_due  = 0;
    if (who == 1) begin
      if (cpu_we) sh_wr(cpu_addr, cpu_din);
      else begin
        m_cpu_due = 1;
        m_cpu_val = sh_rd(cpu_addr);
      end
      m_hold_a = cpu_addr;
      m_hold_d = cpu_din;
    end else if (who == 2) begin
      sh_wr(m_ldq[0].a, m_ldq[0].d);
      m_hold_a = m_ldq[0].a;
      m_hold_d = m_ldq[0].d;
      void'(m_ldq.pop_front());
      m_last_ld = 1;
    end else if (who == 3) begin
      exp_q.push_back(sh_rd(m_tp_addr));
      m_tp_due  = 1;
      m_tp_pend = 0;
      m_last_ld = 0;
      m_hold_a  = m_tp_addr;
    end
    if (ld_wr) begin
      if (m_ldq.size() == 0) begin
        m_ldq.push_back('{a: ld_addr, d: ld_data});
        ld_new = 1'b1;
      end else begin
        m_ovf = 1;
      end
    end
    if (tp_req && !tp_busy) begin
      m_tp_pend = 1;
      m_tp_addr = tp_addr;
      tp_new    = 1'b1;
    end
    m_ld_age = ld_new ? 0 : (m_ldq.size() != 0 ? m_ld_age + 1 : 0);
    m_tp_age = tp_new ? 0 : (m_tp_pend ? m_tp_age + 1 : 0);
  endtask

  // ---------------- driver ----------------
  task automatic run_cycle(input vec_t v, input bit use_exp);
    reset    = v.rst;
    cpu_ce   = v.ce;   cpu_we  = v.cwe; cpu_addr = v.ca; cpu_din = v.cd;
    ld_wr    = v.lw;   ld_addr = v.la;  ld_data  = v.ldd;
    tp_req   = v.tr;   tp_addr = v.ta;
    @(negedge clk_sys);
    model_check();
    if (use_exp) begin
      chk("t_mem_we", {31'd0, mem_we}, {31'd0, v.ewe});
      chk("t_mem_addr", {16'd0, mem_addr}, {16'd0, v.ea});
      chk("t_mem_din", {24'd0, mem_din}, {24'd0, v.ed});
      chk("t_ld_busy", {31'd0, ld_busy}, {31'd0, v.ebusy});
      chk("t_ld_ovf", {31'd0, ld_ovf}, {31'd0, v.eovf});
      chk("t_tp_ack", {31'd0, tp_ack}, {31'd0, v.eack});
      chk("t_tp_q", {24'd0, tp_q}, {24'd0, v.etpq});
      chk("t_cpu_q", {24'd0, cpu_q}, {24'd0, v.ecpuq});
    end
    @(posedge clk_sys);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk_sys);
    #1;
    pre_we = 1'b0;
    sh_wr(a, d);
  endtask

  // ---------------- directed table + random traffic ----------------
  vec_t vecs [0:23];

  initial begin
    vec_t v;
    bit   prev_ce;
    //            rst  ce   cwe  ca        cd     lw   la        ldd    tr   ta        ewe  ea        ed     busy ovf  ack  tpq    cpuq
    vecs[0]  = '{1'b1,1'b1,1'b1,16'h1234,8'hFF, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00};
    vecs[1]  = '{1'b0,1'b1,1'b0,16'h3900,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h3900,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00};
    vecs[2]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h3900,8'h00, 1'b0,1'b0,1'b0,8'h00,8'hA5};
    vecs[3]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h3900,8'h00, 1'b0,1'b0,1'b0,8'h00,8'hA5};
    vecs[4]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,16'hC000,8'h5A, 1'b0,16'h0000, 1'b0,16'h3900,8'h00, 1'b0,1'b0,1'b0,8'h00,8'hA5};
    vecs[5]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b1,16'hC000,8'h5A, 1'b1,1'b0,1'b0,8'h00,8'hA5};
    vecs[6]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'hC000,8'h5A, 1'b0,1'b0,1'b0,8'h00,8'hA5};
    vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,16'hC100,8'h11, 1'b0,16'h0000, 1'b0,16'hC000,8'h5A, 1'b0,1'b0,1'b0,8'h00,8'hA5};
    vecs[8]  = '{1'b0,1'b1,1'b0,16'h0010,8'h00, 1'b1,16'hC101,8'h22, 1'b0,16'h0000, 1'b0,16'h0010,8'h00, 1'b1,1'b0,1'b0,8'h00,8'hA5};
    vecs[9]  = '{1'b0,1'b1,1'b0,16'h3900,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h3900,8'h00, 1'b1,1'b1,1'b0,8'h00,8'h3C};
    vecs[10] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b1,16'hC100,8'h11, 1'b1,1'b1,1'b0,8'h00,8'hA5};
    vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'hC100,8'h11, 1'b0,1'b1,1'b0,8'h00,8'hA5};
    vecs[12] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,16'hC200,8'h77, 1'b1,16'h0010, 1'b0,16'hC100,8'h11, 1'b0,1'b1,1'b0,8'h00,8'hA5};
    vecs[13] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h0010,8'h11, 1'b1,1'b1,1'b0,8'h00,8'hA5};
    vecs[14] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b1,16'hC200,8'h77, 1'b1,1'b1,1'b1,8'h3C,8'hA5};
    vecs[15] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'hC200,8'h77, 1'b0,1'b1,1'b0,8'h3C,8'hA5};
    vecs[16] = '{1'b0,1'b1,1'b1,16'hC300,8'h99, 1'b0,16'h0000,8'h00, 1'b1,16'hC200, 1'b1,16'hC300,8'h99, 1'b0,1'b1,1'b0,8'h3C,8'hA5};
    vecs[17] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'hC200,8'h99, 1'b0,1'b1,1'b0,8'h3C,8'hA5};
    vecs[18] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'hC200,8'h99, 1'b0,1'b1,1'b1,8'h77,8'hA5};
    vecs[19] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b1,16'h3900, 1'b0,16'hC200,8'h99, 1'b0,1'b1,1'b0,8'h77,8'hA5};
    vecs[20] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,16'hC400,8'h44, 1'b0,16'h0000, 1'b0,16'h3900,8'h99, 1'b0,1'b1,1'b0,8'h77,8'hA5};
    vecs[21] = '{1'b1,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h3900,8'h99, 1'b1,1'b1,1'b0,8'h77,8'hA5};
    vecs[22] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00};
    vecs[23] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,16'h0000,8'h00, 1'b0,16'h0000, 1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00};

    // Hold the DUT in reset while the RAM is seeded.
    reset = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_din = 8'h0;
    ld_wr = 1'b0; ld_addr = 16'h0; ld_data = 8'h0; tp_req = 1'b0; tp_addr = 16'h0;
    @(posedge clk_sys);
    #1;
    preload(16'h3900, 8'hA5);
    preload(16'h0010, 8'h3C);
    preload(16'hC101, 8'h00);
    preload(16'hC400, 8'h00);
    model_reset();

    for (int i = 0; i < 24; i++) run_cycle(vecs[i], 1'b1);

    // Dropped loader byte and reset-discarded byte never reached the RAM.
    chk("ram_c100_first_byte", {24'd0, ram_rd(16'hC100)}, 32'h11);
    chk("ram_c101_dropped", {24'd0, ram_rd(16'hC101)}, 32'h00);
    chk("ram_c400_discarded", {24'd0, ram_rd(16'hC400)}, 32'h00);
    chk("ram_c300_cpu_write", {24'd0, ram_rd(16'hC300)}, 32'h99);

    // Random traffic on a small address window so accesses collide.
    fair_on = 1'b1;
    prev_ce = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      v       = '0;
      v.rst   = ($urandom_range(0, 249) == 0);
      v.ce    = prev_ce ? 1'b0 : ($urandom_range(0, 2) == 0);
      v.cwe   = $urandom_range(0, 1) == 1;
      v.ca    = 16'hC000 | 16'($urandom_range(0, 7));
      v.cd    = 8'($urandom_range(0, 255));
      v.lw    = ($urandom_range(0, 2) == 0);
      v.la    = 16'hC000 | 16'($urandom_range(0, 7));
      v.ldd   = 8'($urandom_range(0, 255));
      v.tr    = ($urandom_range(0, 3) == 0);
      v.ta    = 16'hC000 | 16'($urandom_range(0, 7));
      prev_ce = v.ce;
      run_cycle(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
